uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one `uart_tx` serializer between `NUM_REQ` byte requesters. Arbitration is round-robin, and the grant is held for a whole packet. The block sits between the requester logic (status/timestamp reporters) and the `uart_tx` instance. It drives `i_Tx_DV`/`i_Tx_Byte` and consumes `o_Tx_Done`/`o_Tx_Active`. It never drives the DV line while the serializer is in its stop or cleanup phase, and it recovers from a hung serializer with a watchdog.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..16.
- `TIMEOUT_CLKS`, 20000 — maximum clocks spent in WAIT before abort. Must exceed 10×CLKS_PER_BIT+2.
- `i_Clock` in 1 — single clock for the block.
- `i_Rst_n` in 1 — reset, synchronous, active-low.
- `i_Req_Valid` in NUM_REQ — requester r has a byte pending.
- `i_Req_Byte` in 8×NUM_REQ — byte of requester r on bits [8r+7:8r].
- `i_Req_Last` in NUM_REQ — pending byte ends requester r's packet.
- `o_Req_Ready` out NUM_REQ — one-cycle pulse; the byte is consumed on this edge.
- `o_Tx_DV` out 1 — to `uart_tx.i_Tx_DV`; one-cycle pulse.
- `o_Tx_Byte` out 8 — to `uart_tx.i_Tx_Byte`; stable while DV is high.
- `i_Tx_Active` in 1 — from `uart_tx.o_Tx_Active`.
- `i_Tx_Done` in 1 — from `uart_tx.o_Tx_Done`.
- `o_Grant` out NUM_REQ — one-hot current owner; 0 when idle.
- `o_Busy` out 1 — high whenever the state is not IDLE.
- `o_Timeout` out 1 — one-cycle pulse when the watchdog aborts.

## Operation
- **Reset** (`i_Rst_n`=0 at the edge): state=IDLE; rr pointer=0; all outputs 0 (`o_Tx_Byte`=8'h00, `o_Grant`=0, `o_Req_Ready`=0).
- **IDLE:** search `i_Req_Valid` starting from the pointer, ascending and wrapping. The first hit r sets `o_Grant`=1<<r, then go to TAG (macro on) or FETCH. No valid bits: stay.
- **FETCH:**
  - `i_Req_Valid[g]`=1: `o_Req_Ready[g]`=1 combinationally this cycle; latch the byte into `o_Tx_Byte` and `i_Req_Last[g]` into last_r; go to LOAD.
  - Valid low: stay, with the lock held (no timeout in FETCH).
- **TAG:** `o_Tx_Byte`=8'hA0|g, last_r=0, go to LOAD.
- **LOAD:** `o_Tx_DV`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- **WAIT:**
  - `i_Tx_Done`=1: go to GAP.
  - Counter reaches TIMEOUT_CLKS−1: pulse `o_Timeout`, clear `o_Grant`, pointer=g+1 mod NUM_REQ, go to IDLE.
- **GAP:** one cycle, which covers the serializer's cleanup cycle.
  - last_r=1: clear `o_Grant`, pointer=g+1 mod NUM_REQ, go to IDLE.
  - Otherwise: go to FETCH.
- **Packet lock:** other requesters' valid bits are ignored from grant until the Last byte completes or a timeout occurs.
- `o_Req_Ready` is only ever asserted for the granted index, and at most once per transmitted byte.
- `i_Tx_Active` is used only as a guard: LOAD is not entered while it is 1. If it is, wait in the pre-LOAD state.
- Watchdog counter width is $clog2(TIMEOUT_CLKS)+1. It saturates and does not wrap.
- A requester dropping valid after ready is legal. Changing the byte while valid and not ready is a requester error; behaviour is undefined.

## Timing
- Single valid arriving at IDLE cycle t: `o_Grant` at t+1, ready at t+1 (no tag), DV at t+2.
- `i_Tx_Done` pulse at cycle d: GAP at d+1, FETCH at d+2, next DV at d+3 at the earliest. The serializer is back in its idle state by d+2.
- Per-byte overhead beyond the UART frame: 3 clocks within a packet, 4 clocks between packets (IDLE cycle).
- The pointer advances only at packet end or timeout, never per byte.
- Reset mid-operation: the next cycle is IDLE with outputs 0. A byte already handed to `uart_tx` completes on the line, but its Done is ignored (the block is in IDLE).

## Configuration
- `UART_TX_ARB_TAG_EN` defined: every packet is preceded by a tag byte 8'hA0|g. Within a packet, the first requester ready comes only after the tag's GAP.
- Undefined: the TAG state is absent, IDLE goes directly to FETCH, and only payload bytes are sent.

## Test plan
- **Single byte:** req0 sends 8'h55 with last=1 → one DV with byte 8'h55, ready0 pulses once, `o_Grant` returns to 0 one cycle after GAP, pointer=1.
- **Round-robin:** req1 and req2 are both valid with single-byte packets from reset → bytes sent in order req1, req2; repeating after the pointer reaches 3 gives order req0 (if valid), then req1.
- **Lock:** req0 sends 3 bytes 11/22/33 (last on 33) while req3 is valid throughout → line carries 11,22,33 then req3's byte; `o_Req_Ready[3]` stays low until req0's packet ends.
- **Watchdog:** `i_Tx_Done` is held low after DV → `o_Timeout` pulses exactly TIMEOUT_CLKS cycles after LOAD, grant clears, and the next requester is served.
- **Reset during WAIT:** assert `i_Rst_n`=0 for 1 cycle → all outputs 0 next cycle; a later Done pulse causes no DV and no ready.
- **Tag (`UART_TX_ARB_TAG_EN` defined):** req2 sends 8'h7E, last=1 → DV bytes 8'hA2 then 8'h7E, with the second DV exactly 3 cycles after the tag's Done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx serializer among NUM_REQ requesters.
// Define UART_TX_ARB_TAG_EN to precede every packet with a tag byte 8'hA0|owner.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int TIMEOUT_CLKS = 20000
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic [NUM_REQ-1:0]   i_Req_Valid,
   input  logic [8*NUM_REQ-1:0] i_Req_Byte,
   input  logic [NUM_REQ-1:0]   i_Req_Last,
   output logic [NUM_REQ-1:0]   o_Req_Ready,
   output logic                 o_Tx_DV,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Active,
   input  logic                 i_Tx_Done,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic                 o_Busy,
   output logic                 o_Timeout
);
   // state | meaning
   // IDLE  | no owner; round-robin search from r_ptr
   // TAG   | owner chosen; tag byte staged once serializer is idle
   // FETCH | packet locked to owner; take its next byte once serializer is idle
   // LOAD  | DV pulse to serializer, watchdog cleared
   // WAIT  | frame on the line; wait for Done or watchdog
   // GAP   | serializer cleanup cycle; end packet or fetch next byte
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CLKS) + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4
`ifdef UART_TX_ARB_TAG_EN
      ,S_TAG  = 3'd5
`endif
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_ptr;
   logic [IW-1:0]     r_gidx;
   logic [NUM_REQ-1:0] r_grant;
   logic              r_last;
   logic              r_tx_dv;
   logic [7:0]        r_tx_byte;
   logic [CW-1:0]     r_wdog;
   logic              r_timeout;

   logic              w_hit;
   logic [IW-1:0]     w_hit_idx;
   logic [IW-1:0]     w_next_ptr;
   logic              w_fetch_go;
   logic [7:0]        w_byte_g;

   always_comb begin
      int j;
      j         = 0;
      w_hit     = 1'b0;
      w_hit_idx = '0;
      // descending scan so the lowest offset from r_ptr wins
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = int'(r_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (i_Req_Valid[IW'(j)]) begin
            w_hit     = 1'b1;
            w_hit_idx = IW'(j);
         end
      end
   end

   assign w_next_ptr  = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);
   assign w_byte_g    = i_Req_Byte[{r_gidx, 3'b000} +: 8];
   assign w_fetch_go  = (r_state == S_FETCH) && i_Req_Valid[r_gidx] && !i_Tx_Active && i_Rst_n;
   assign o_Req_Ready = w_fetch_go ? r_grant : '0;

   assign o_Tx_DV   = r_tx_dv;
   assign o_Tx_Byte = r_tx_byte;
   assign o_Grant   = r_grant;
   assign o_Busy    = (r_state != S_IDLE);
   assign o_Timeout = r_timeout;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_gidx    <= '0;
         r_grant   <= '0;
         r_last    <= 1'b0;
         r_tx_dv   <= 1'b0;
         r_tx_byte <= 8'h00;
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_tx_dv   <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_grant            <= '0;
                  r_grant[w_hit_idx] <= 1'b1;
                  r_gidx             <= w_hit_idx;
`ifdef UART_TX_ARB_TAG_EN
                  r_state            <= S_TAG;
`else
                  r_state            <= S_FETCH;
`endif
               end
            end
`ifdef UART_TX_ARB_TAG_EN
            S_TAG: begin
               if (!i_Tx_Active) begin
                  r_tx_byte <= 8'hA0 | 8'(r_gidx);
                  r_last    <= 1'b0;
                  r_tx_dv   <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end
`endif
            S_FETCH: begin
               if (w_fetch_go) begin
                  r_tx_byte <= w_byte_g;
                  r_last    <= i_Req_Last[r_gidx];
                  r_tx_dv   <= 1'b1;
                  r_state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_wdog  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wdog != '1) r_wdog <= r_wdog + CW'(1);
               if (i_Tx_Done) begin
                  r_state <= S_GAP;
               end else if (r_wdog == CW'(TIMEOUT_CLKS - 2)) begin
                  // abort on the edge where the count reaches TIMEOUT_CLKS-1
                  r_timeout <= 1'b1;
                  r_grant   <= '0;
                  r_ptr     <= w_next_ptr;
                  r_state   <= S_IDLE;
               end
            end
            S_GAP: begin
               if (r_last) begin
                  r_grant <= '0;
                  r_ptr   <= w_next_ptr;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural serializer, requester queues and a packet-order reference model.
// Honors UART_TX_ARB_TAG_EN when defined (expects a tag byte ahead of every packet).
module tb_uart_tx_arbiter;
   localparam int NREQ  = 4;
   localparam int TMO   = 40;
   localparam int FRAME = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*NREQ-1:0] req_byte;
   logic              tx_dv, tx_active, tx_done, busy, tmo;
   logic [7:0]        tx_byte;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CLKS(TMO)) dut (
      .i_Clock(clk), .i_Rst_n(rst_n),
      .i_Req_Valid(req_valid), .i_Req_Byte(req_byte), .i_Req_Last(req_last),
      .o_Req_Ready(req_ready), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
      .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
      .o_Grant(grant), .o_Busy(busy), .o_Timeout(tmo)
   );

   typedef struct { logic [7:0] b; int r; bit start; } exp_t;
   exp_t       exp_q[$];
   logic [7:0] rq_b[NREQ][$];
   bit         rq_l[NREQ][$];

   int vectors = 0, miscompares = 0;
   int cyc = 0, last_done = -1, to_cyc = -1, to_hits = 0, m_ptr = 0, ser_cnt = 0;
   bit hang_arm = 0, chk_zero = 0, ser_hang = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic drive_inputs();
      for (int r = 0; r < NREQ; r++) begin
         req_valid[r]       = rq_b[r].size() > 0;
         req_byte[8*r +: 8] = (rq_b[r].size() > 0) ? rq_b[r][0] : 8'h00;
         req_last[r]        = (rq_l[r].size() > 0) ? rq_l[r][0] : 1'b0;
      end
   endtask

   task automatic load(input int r, input logic [7:0] b, input bit last);
      rq_b[r].push_back(b);
      rq_l[r].push_back(last);
   endtask

   // Reference: whole packets in round-robin order from the model pointer.
   task automatic start_scenario();
      int   idx[NREQ];
      int   p;
      int   r;
      int   c;
      bit   end_pkt;
      bit   first;
      exp_t e;
      for (int k = 0; k < NREQ; k++) idx[k] = 0;
      p = m_ptr;
      while (1) begin
         r = -1;
         for (int k = 0; k < NREQ; k++) begin
            c = (p + k) % NREQ;
            if (r < 0 && idx[c] < rq_b[c].size()) r = c;
         end
         if (r < 0) break;
         first = 1;
`ifdef UART_TX_ARB_TAG_EN
         e.b = 8'hA0 | 8'(r); e.r = r; e.start = 1;
         exp_q.push_back(e);
         first = 0;
`endif
         end_pkt = 0;
         while (!end_pkt && idx[r] < rq_b[r].size()) begin
            e.b = rq_b[r][idx[r]]; e.r = r; e.start = first;
            exp_q.push_back(e);
            end_pkt = rq_l[r][idx[r]];
            idx[r]++;
            first = 0;
         end
         p = (r + 1) % NREQ;
      end
      m_ptr = p;
      last_done = -1;
      drive_inputs();
   endtask

   task automatic step();
      logic [NREQ-1:0] rdy;
      bit   dv;
      bit   hang_now;
      exp_t e;
      @(negedge clk);
      cyc++;
      rdy = req_ready;
      dv = tx_dv;
      hang_now = 0;
      if (chk_zero) begin
         chk("rst_grant", 32'(grant), 0);
         chk("rst_dv", 32'(tx_dv), 0);
         chk("rst_byte", 32'(tx_byte), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_ready", 32'(req_ready), 0);
         chk("rst_timeout", 32'(tmo), 0);
         chk_zero = 0;
      end
      if (tx_done) last_done = cyc;
      chk("busy_vs_grant", 32'(busy), 32'(|grant));
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      chk("ready_outside_grant", 32'(rdy & ~grant), 0);
      chk("timeout_pulse", 32'(tmo), 32'(cyc == to_cyc));
      if (tmo) begin
         to_hits++;
         chk("grant_after_timeout", 32'(grant), 0);
      end
      for (int r = 0; r < NREQ; r++)
         if (rdy[r]) chk("ready_with_data", 32'(rq_b[r].size() > 0), 1);
      if (dv) begin
         chk("dv_while_serializer_busy", 32'(tx_active | tx_done), 0);
         chk("dv_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_byte", 32'(tx_byte), 32'(e.b));
            chk("tx_owner", 32'(grant), 32'(1 << e.r));
            if (last_done >= 0) chk("dv_gap_after_done", 32'(cyc - last_done), e.start ? 4 : 3);
         end
         if (hang_arm) begin
            hang_now = 1;
            hang_arm = 0;
            to_cyc = cyc + TMO;
         end
         last_done = -1;
      end
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++)
         if (rdy[r] && rq_b[r].size() > 0) begin
            void'(rq_b[r].pop_front());
            void'(rq_l[r].pop_front());
         end
      tx_done = 1'b0;
      if (dv) begin
         tx_active = 1'b1;
         ser_cnt = FRAME;
         ser_hang = hang_now;
      end else if (ser_cnt > 0) begin
         ser_cnt--;
         if (ser_cnt == 0) begin
            tx_active = 1'b0;
            tx_done = !ser_hang;
         end
      end
      drive_inputs();
   endtask

   task automatic drain(input int budget);
      int n;
      bit idle;
      bit empty;
      n = 0;
      idle = 0;
      while (!idle && n < budget) begin
         step();
         n++;
         empty = 1;
         for (int r = 0; r < NREQ; r++) if (rq_b[r].size() > 0) empty = 0;
         idle = empty && exp_q.size() == 0 && !busy && ser_cnt == 0 && !tx_done && cyc > to_cyc;
      end
      chk("drain_in_budget", 32'(idle), 1);
      chk("all_bytes_sent", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int n;
      int npk;
      int len;
      rst_n = 1'b0;
      tx_active = 1'b0;
      tx_done = 1'b0;
      drive_inputs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_zero = 1;

      // single byte from requester 0
      load(0, 8'h55, 1);
      start_scenario();
      drain(200);

      // round-robin: 1 then 2, then with pointer at 3: 0 then 1
      load(1, 8'h61, 1); load(2, 8'h62, 1);
      start_scenario();
      drain(300);
      load(0, 8'h70, 1); load(1, 8'h71, 1);
      start_scenario();
      drain(300);

      // reset while the first byte of a packet is in flight
      load(0, 8'hA1, 0); load(0, 8'hA2, 1);
      start_scenario();
      n = 0;
      while (exp_q.size() > 1 && n < 100) begin step(); n++; end
      chk("reset_scn_first_dv", 32'(exp_q.size()), 1);
      repeat (3) step();
      rst_n = 1'b0;
      for (int r = 0; r < NREQ; r++) begin rq_b[r].delete(); rq_l[r].delete(); end
      exp_q.delete();
      drive_inputs();
      step();
      rst_n = 1'b1;
      chk_zero = 1;
      m_ptr = 0;
      drain(200);

      // packet lock: req0 11/22/33 while req3 waits
      load(0, 8'h11, 0); load(0, 8'h22, 0); load(0, 8'h33, 1); load(3, 8'h44, 1);
      start_scenario();
      drain(500);

      // watchdog: first frame never reports Done
      to_hits = 0;
      hang_arm = 1;
      load(1, 8'h5A, 1); load(2, 8'hC3, 1);
      start_scenario();
      drain(500);
      chk("timeout_count", 32'(to_hits), 1);

      // randomized packets
      for (int round = 0; round < 6; round++) begin
         for (int r = 0; r < NREQ; r++) begin
            npk = $urandom_range(0, 2);
            for (int p = 0; p < npk; p++) begin
               len = $urandom_range(1, 3);
               for (int k = 0; k < len; k++) load(r, 8'($urandom), k == len - 1);
            end
         end
         start_scenario();
         drain(2500);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
